// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack channel between the fetch unit and imem.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    // Fetch unit side: issues requests, receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    // Memory side: serves requests.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and imem fetch FSM for the multicycle CPU.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PCWre,
    input  logic                   IRWre,
    input  logic [1:0]             PCSrc,
    input  logic [31:0]            imm_ext,
    input  logic [31:0]            rs_data,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            ir,
    output logic                   ir_valid,
    output logic                   fetch_busy,
    output logic [31:0]            link_addr,
    output logic                   halted,
    output logic                   overlap_err,
    output logic [31:0]            fetch_count
);

    localparam int unsigned W = 32;

    localparam logic [0:0] F_IDLE = 1'b0;
    localparam logic [0:0] F_WAIT = 1'b1;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JR     = 2'b10;
    localparam logic [1:0] SRC_JUMP   = 2'b11;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] ir_q, ir_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] link_q, link_d;
    logic [W-1:0] count_q, count_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         halted_q, halted_d;
    logic         ovl_q, ovl_d;
    logic [W-1:0] next_pc;

    // Next-PC selection; all adds wrap modulo 2^32.
    always_comb begin
        next_pc = pc_q + W'(4);
        case (PCSrc)
            SRC_SEQ:    next_pc = pc_q + W'(4);
            SRC_BRANCH: next_pc = pc_q + (imm_ext << 2);
            SRC_JR:     next_pc = rs_data & 32'hFFFF_FFFC;
            SRC_JUMP:   next_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    // Next-state and registered-output logic for PC and the fetch FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        link_d   = link_q;
        count_d  = count_q;
        req_d    = req_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        halted_d = halted_q;
        ovl_d    = ovl_q;

        if (PCWre && !halted_q) begin
            pc_d = next_pc;
        end

        case (state_q)
            F_IDLE: begin
                // Fetch address is the pre-update PC even when PCWre fires together.
                if (IRWre && !halted_q) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (IRWre) begin
                    ovl_d = 1'b1;
                end
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    link_d  = addr_q + W'(4);
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    count_d = count_q + W'(1);
                    if (imem.imem_rdata[31:26] == HALT_OP) begin
                        halted_d = 1'b1;
                    end
                    state_d = F_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= F_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            addr_q   <= '0;
            link_q   <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            ovl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            addr_q   <= addr_d;
            link_q   <= link_d;
            count_q  <= count_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            ovl_q    <= ovl_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_valid       = valid_q;
    assign fetch_busy     = busy_q;
    assign link_addr      = link_q;
    assign halted         = halted_q;
    assign overlap_err    = ovl_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWre, IRWre;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext, rs_data;
    logic [31:0] pc, ir, link_addr, fetch_count;
    logic        ir_valid, fetch_busy, halted, overlap_err;

    pc_fetch_unit_if imem_if ();

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCWre       (PCWre),
        .IRWre       (IRWre),
        .PCSrc       (PCSrc),
        .imm_ext     (imm_ext),
        .rs_data     (rs_data),
        .imem        (imem_if),
        .pc          (pc),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .fetch_busy  (fetch_busy),
        .link_addr   (link_addr),
        .halted      (halted),
        .overlap_err (overlap_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_ir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a fetch; optionally advance PC sequentially in the same edge.
    task automatic launch(input logic pcwre, input logic [31:0] instr);
        exp_t e;
        e.addr  = exp_pc;
        e.instr = instr;
        sb_q.push_back(e);
        IRWre = 1'b1;
        PCWre = pcwre;
        PCSrc = 2'b00;
        tick();
        IRWre = 1'b0;
        PCWre = 1'b0;
        if (pcwre) exp_pc = exp_pc + 32'd4;
        chk("launch_req", 32'(imem_if.imem_req), 32'd1);
        chk("launch_busy", 32'(fetch_busy), 32'd1);
        chk("launch_valid", 32'(ir_valid), 32'd0);
        chk("launch_addr", imem_if.imem_addr, e.addr);
        chk("launch_pc", pc, exp_pc);
    endtask

    // Hold off the ack for extra_wait cycles, then complete and score the fetch.
    task automatic complete(input int extra_wait, input logic [31:0] instr);
        exp_t e;
        int   held = 0;
        for (int i = 0; i < extra_wait; i++) begin
            tick();
            if (imem_if.imem_req === 1'b1) held++;
        end
        chk("req_hold", 32'(held), 32'(extra_wait));
        imem_if.imem_rdata = instr;
        imem_if.imem_ack   = 1'b1;
        tick();
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'hA5A5_A5A5;
        exp_cnt = exp_cnt + 32'd1;
        e = sb_q.pop_front();
        exp_ir = e.instr;
        chk("done_ir", ir, e.instr);
        chk("done_link", link_addr, e.addr + 32'd4);
        chk("done_valid", 32'(ir_valid), 32'd1);
        chk("done_req", 32'(imem_if.imem_req), 32'd0);
        chk("done_busy", 32'(fetch_busy), 32'd0);
        chk("done_count", fetch_count, exp_cnt);
    endtask

    task automatic pcstep(input logic [1:0] src, input logic [31:0] imm,
                          input logic [31:0] rs, input logic [31:0] exp);
        PCSrc   = src;
        imm_ext = imm;
        rs_data = rs;
        PCWre   = 1'b1;
        tick();
        PCWre   = 1'b0;
        exp_pc  = exp;
        chk("pc_step", pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        PCWre = 1'b0;
        IRWre = 1'b0;
        PCSrc = 2'b00;
        imm_ext = '0;
        rs_data = '0;
        imem_if.imem_rdata = 32'hA5A5_A5A5;
        imem_if.imem_ack   = 1'b0;
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        #22;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_addr", imem_if.imem_addr, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_flags", {27'd0, imem_if.imem_req, ir_valid, fetch_busy, halted, overlap_err}, 32'h0);
        reset = 1'b1;
        tick();

        // First fetch with PC advance, ack three cycles after launch.
        launch(1'b1, 32'h0822_0005);
        complete(2, 32'h0822_0005);
        chk("t1_pc", pc, 32'h4);
        chk("t1_addr", imem_if.imem_addr, 32'h0);

        // Sequential, branch backwards, jr with low bits masked.
        pcstep(2'b00, 32'h0, 32'h0, 32'h8);
        pcstep(2'b01, 32'hFFFF_FFFE, 32'h0, 32'h0);
        pcstep(2'b10, 32'h0, 32'h0000_0013, 32'h10);

        // Jump composes pc[31:28] with ir[25:0].
        pcstep(2'b10, 32'h0, 32'h4000_0004, 32'h4000_0004);
        launch(1'b0, 32'hE000_0010);
        complete(0, 32'hE000_0010);
        pcstep(2'b11, 32'h0, 32'h0, 32'h4000_0040);
        pcstep(2'b10, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        pcstep(2'b00, 32'h0, 32'h0, 32'h0);

        // Overlapping IRWre while busy; PC still advances.
        pcstep(2'b10, 32'h0, 32'h20, 32'h20);
        launch(1'b0, 32'h1234_5678);
        IRWre = 1'b1;
        PCWre = 1'b1;
        PCSrc = 2'b00;
        tick();
        IRWre = 1'b0;
        PCWre = 1'b0;
        exp_pc = 32'h24;
        chk("ovl_err", 32'(overlap_err), 32'd1);
        chk("ovl_addr", imem_if.imem_addr, 32'h20);
        chk("ovl_pc", pc, 32'h24);
        complete(1, 32'h1234_5678);

        // Stray ack while idle is ignored.
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        imem_if.imem_ack   = 1'b1;
        tick();
        imem_if.imem_ack   = 1'b0;
        chk("stray_ir", ir, exp_ir);
        chk("stray_count", fetch_count, exp_cnt);
        chk("stray_req", 32'(imem_if.imem_req), 32'd0);

        // Halt opcode freezes PC and fetch.
        launch(1'b0, 32'hFC00_0000);
        complete(1, 32'hFC00_0000);
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            IRWre = 1'b1;
            PCWre = 1'b1;
            PCSrc = 2'(i);
            tick();
        end
        IRWre = 1'b0;
        PCWre = 1'b0;
        chk("halt_pc", pc, exp_pc);
        chk("halt_ir", ir, 32'hFC00_0000);
        chk("halt_req", 32'(imem_if.imem_req), 32'd0);
        chk("halt_count", fetch_count, exp_cnt);
        chk("ovl_sticky", 32'(overlap_err), 32'd1);

        // Reset clears halt; then reset in the middle of an outstanding fetch.
        reset = 1'b0;
        #3;
        reset = 1'b1;
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        chk("rst2_halted", 32'(halted), 32'd0);
        tick();
        launch(1'b1, 32'h0000_0000);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_if.imem_req), 32'd0);
        chk("midrst_busy", 32'(fetch_busy), 32'd0);
        sb_q.delete();
        tick();
        tick();
        reset = 1'b1;
        imem_if.imem_rdata = 32'h0822_0005;
        imem_if.imem_ack   = 1'b1;
        tick();
        imem_if.imem_ack   = 1'b0;
        chk("late_ir", ir, 32'h0);
        chk("late_valid", 32'(ir_valid), 32'd0);
        chk("late_count", fetch_count, 32'h0);
        chk("late_req", 32'(imem_if.imem_req), 32'd0);
        chk("late_pc", pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
